// File: rtl/jk_sync_counter.sv
// Loadable, cascadable synchronous up/down counter with a programmable modulus.
// Counts on rising edges of cnt_clk as sampled by MasterClock; stages chain through ci/co.
module jk_sync_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16
) (
    input  logic             MasterClock,
    input  logic             rL,
    input  logic             cnt_clk,
    input  logic             ci,
    input  logic             ld,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qL,
    output logic             co,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             oldClk_q;
    logic             tc_q, tc_d;
    logic             ev;
    logic             atTerm;

    assign ev     = cnt_clk & ~oldClk_q;
    assign atTerm = up ? (count_q == TERM_UP) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (ev) begin
            if (ld) begin
                count_d = d;
            end else if (ci) begin
                tc_d = atTerm;
                if (up) begin
                    count_d = atTerm ? '0 : count_q + 1'b1;
                end else begin
                    count_d = atTerm ? TERM_UP : count_q - 1'b1;
                end
            end
        end
    end

    // Edge-detect register resets high so a strobe held across reset release never counts.
    always_ff @(posedge MasterClock or negedge rL) begin
        if (!rL) begin
            count_q  <= '0;
            oldClk_q <= 1'b1;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            oldClk_q <= cnt_clk;
            tc_q     <= tc_d;
        end
    end

    assign q  = count_q;
    assign qL = ~count_q;
    assign co = ci & atTerm;
    assign tc = tc_q;

endmodule
